// File: rtl/ber_iq_counter.sv
// Bit-error-rate counter for a QPSK receiver. During a fixed sync window it
// searches the reference delay and 90-degree rotation giving the fewest
// errors, then counts compared bits and bit errors on each branch.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for i_count_sym == START_SYN, counters held at 0
// S_SYNC  | sweeping candidate delays, 4 rotations scored in parallel
// S_COUNT | locked on best delay/rotation, counting bits and errors
module ber_iq_counter #(
  parameter int CNT_BER   = 64,
  parameter int CNT_ERR   = 64,
  parameter int PRBS_CYCL = 511,
  parameter int COMB_PRBS = 511,
  parameter int START_SYN = 249879,
  parameter int START_CNT = START_SYN + COMB_PRBS * PRBS_CYCL
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [32:0]        i_count_sym,
  input  logic               i_prbs_I,
  input  logic               i_prbs_Q,
  input  logic               i_rx_bit_I_demap,
  input  logic               i_rx_bit_Q_demap,
  output logic [CNT_BER-1:0] o_cnt_ber_I,
  output logic [CNT_BER-1:0] o_cnt_ber_Q,
  output logic [CNT_ERR-1:0] o_cnt_err_ber_I,
  output logic [CNT_ERR-1:0] o_cnt_err_ber_Q,
  output logic [1:0]         o_rot_ang_detec
);

  localparam int AW    = $clog2(2 * PRBS_CYCL + 1);
  localparam int CW    = $clog2(PRBS_CYCL + 1);
  localparam int DW    = $clog2(COMB_PRBS + 1);
  // Window count follows from the sync span, which equals COMB_PRBS windows.
  localparam int N_WIN = (START_CNT - START_SYN) / PRBS_CYCL;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SYNC  = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;

  logic [1:0]           r_state;
  logic [COMB_PRBS-1:0] r_dly_I, r_dly_Q;
  logic [COMB_PRBS:0]   w_tap_I, w_tap_Q;
  logic [CW-1:0]        r_cyc, w_cyc;
  logic [DW-1:0]        r_d, r_best_d, w_best_d;
  logic [AW-1:0]        r_acc [4];
  logic [AW-1:0]        w_acc_nxt [4];
  logic [1:0]           w_corr_s [4];
  logic [1:0]           w_e_s [4];
  logic [AW-1:0]        r_best_err, w_best_err;
  logic [1:0]           r_best_k, w_best_k, r_rot;
  logic                 w_trig, w_act, w_win_end, w_last;
  logic                 w_ref_s_I, w_ref_s_Q, w_ref_c_I, w_ref_c_Q;
  logic [1:0]           w_corr_c;
  logic                 w_err_c_I, w_err_c_Q;
  logic [CNT_BER-1:0]   r_ber_I, r_ber_Q;
  logic [CNT_ERR-1:0]   r_err_I, r_err_Q;

  // Undo rotation candidate k: returns corrected {I', Q'}.
  function automatic logic [1:0] f_rot(input logic [1:0] k, input logic ri, input logic rq);
    case (k)
      2'd0:    f_rot = {ri, rq};
      2'd1:    f_rot = {rq, ~ri};
      2'd2:    f_rot = {~ri, ~rq};
      default: f_rot = {~rq, ri};
    endcase
  endfunction

  // Tap d is the reference from d clocks ago; tap 0 is the live input.
  assign w_tap_I = {r_dly_I, i_prbs_I};
  assign w_tap_Q = {r_dly_Q, i_prbs_Q};

  assign w_trig    = (r_state == S_IDLE) && (i_count_sym == 33'(START_SYN));
  assign w_act     = w_trig || (r_state == S_SYNC);
  assign w_cyc     = (r_state == S_IDLE) ? CW'(PRBS_CYCL - 1) : r_cyc;
  assign w_win_end = w_act && (w_cyc == '0);
  assign w_last    = w_win_end && (r_d == DW'(N_WIN - 1));

  assign w_ref_s_I = w_tap_I[r_d];
  assign w_ref_s_Q = w_tap_Q[r_d];

  // Per-rotation error of this symbol against the candidate delay.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_corr_s[k]  = f_rot(2'(k), i_rx_bit_I_demap, i_rx_bit_Q_demap);
      w_e_s[k]     = {1'b0, w_corr_s[k][1] ^ w_ref_s_I} + {1'b0, w_corr_s[k][0] ^ w_ref_s_Q};
      w_acc_nxt[k] = r_acc[k] + AW'(w_e_s[k]);
    end
  end

  // Running minimum over rotations; strict compare keeps the earlier candidate on ties.
  always_comb begin
    w_best_err = (r_state == S_IDLE) ? '1 : r_best_err;
    w_best_d   = r_best_d;
    w_best_k   = r_best_k;
    for (int k = 0; k < 4; k++) begin
      if (w_acc_nxt[k] < w_best_err) begin
        w_best_err = w_acc_nxt[k];
        w_best_d   = r_d;
        w_best_k   = 2'(k);
      end
    end
  end

  // Reference delay lines shift every cycle outside reset.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_dly_I <= '0;
      r_dly_Q <= '0;
    end else begin
      r_dly_I <= w_tap_I[COMB_PRBS-1:0];
      r_dly_Q <= w_tap_Q[COMB_PRBS-1:0];
    end
  end

  // FSM and sync search: window timer counts down, delay index counts up.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_cyc      <= '0;
      r_d        <= '0;
      r_best_err <= '0;
      r_best_d   <= '0;
      r_best_k   <= '0;
      r_rot      <= '0;
      for (int k = 0; k < 4; k++) r_acc[k] <= '0;
    end else if (w_act) begin
      if (w_win_end) begin
        for (int k = 0; k < 4; k++) r_acc[k] <= '0;
        r_best_err <= w_best_err;
        r_best_d   <= w_best_d;
        r_best_k   <= w_best_k;
        r_cyc      <= CW'(PRBS_CYCL - 1);
        r_d        <= r_d + 1'b1;
      end else begin
        for (int k = 0; k < 4; k++) r_acc[k] <= w_acc_nxt[k];
        r_cyc <= w_cyc - 1'b1;
        if (w_trig) r_best_err <= '1;
      end
      if (w_last) begin
        r_state <= S_COUNT;
        r_rot   <= w_best_k;
      end else begin
        r_state <= S_SYNC;
      end
    end
  end

  assign w_ref_c_I = w_tap_I[r_best_d];
  assign w_ref_c_Q = w_tap_Q[r_best_d];
  assign w_corr_c  = f_rot(r_best_k, i_rx_bit_I_demap, i_rx_bit_Q_demap);
  assign w_err_c_I = w_corr_c[1] ^ w_ref_c_I;
  assign w_err_c_Q = w_corr_c[0] ^ w_ref_c_Q;

  // Saturating bit and error counters, active only once locked.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_ber_I <= '0;
      r_ber_Q <= '0;
      r_err_I <= '0;
      r_err_Q <= '0;
    end else if (r_state == S_COUNT) begin
      if (r_ber_I != '1) r_ber_I <= r_ber_I + 1'b1;
      if (r_ber_Q != '1) r_ber_Q <= r_ber_Q + 1'b1;
      if (w_err_c_I && (r_err_I != '1)) r_err_I <= r_err_I + 1'b1;
      if (w_err_c_Q && (r_err_Q != '1)) r_err_Q <= r_err_Q + 1'b1;
    end
  end

  assign o_cnt_ber_I     = r_ber_I;
  assign o_cnt_ber_Q     = r_ber_Q;
  assign o_cnt_err_ber_I = r_err_I;
  assign o_cnt_err_ber_Q = r_err_Q;
  assign o_rot_ang_detec = r_rot;

endmodule

// File: tb/tb_ber_iq_counter.sv
// Scoreboard bench for ber_iq_counter with a small sync window (7x7, start 10).
// Narrow counters (7-bit bit count, 4-bit error count) expose saturation.
module tb_ber_iq_counter;

  logic        clk;
  logic        rst_n;
  logic [32:0] count_sym;
  logic        prbs_i, prbs_q, rx_i, rx_q;
  logic [6:0]  ber_i, ber_q;
  logic [3:0]  err_i, err_q;
  logic [1:0]  rot;

  typedef struct {
    int tag;
    int ber;
    int ei;
    int eq;
    int rot_e;
  } exp_t;

  exp_t       q[$];
  int         n_checks = 0;
  int         n_err    = 0;
  logic [6:0] pat      = 7'b0010111;  // PRBS3: 1,1,1,0,1,0,0

  ber_iq_counter #(
    .CNT_BER(7), .CNT_ERR(4), .PRBS_CYCL(7), .COMB_PRBS(7), .START_SYN(10)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .i_count_sym(count_sym),
    .i_prbs_I(prbs_i),
    .i_prbs_Q(prbs_q),
    .i_rx_bit_I_demap(rx_i),
    .i_rx_bit_Q_demap(rx_q),
    .o_cnt_ber_I(ber_i),
    .o_cnt_ber_Q(ber_q),
    .o_cnt_err_ber_I(err_i),
    .o_cnt_err_ber_Q(err_q),
    .o_rot_ang_detec(rot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic pbit(input int n);
    return pat[n % 7];
  endfunction

  task automatic chk(input string nm, input int tag, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s @sym %0d: got %0d, expected %0d", nm, tag, act, exp_v);
    end
  endtask

  task automatic push(input int tag, input int ber, input int ei, input int eq, input int rot_e);
    exp_t e;
    e.tag = tag; e.ber = ber; e.ei = ei; e.eq = eq; e.rot_e = rot_e;
    q.push_back(e);
  endtask

  // Monitor: compare outputs whenever the presented symbol matches a queued tag.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].tag == int'(count_sym)) begin
        e = q.pop_front();
        chk("ber_I", e.tag, int'(ber_i), e.ber);
        chk("ber_Q", e.tag, int'(ber_q), e.ber);
        chk("err_I", e.tag, int'(err_i), e.ei);
        chk("err_Q", e.tag, int'(err_q), e.eq);
        chk("rot",   e.tag, int'(rot),   e.rot_e);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; count_sym = '0;
    prbs_i = 1'b0; prbs_q = 1'b0; rx_i = 1'b0; rx_q = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // mode = rotation the receiver applies; rx is the reference delayed by 3.
  task automatic run_test(input int mode, input int end_s, input int f_lo, input int f_hi,
                          input int rst_at);
    logic di, dq;
    do_reset();
    for (int s = 0; s <= end_s; s++) begin
      count_sym = 33'(s);
      prbs_i = pbit(s);
      prbs_q = pbit(s + 3);
      di = pbit(s + 4);
      dq = pbit(s);
      case (mode)
        1:       begin rx_i = ~dq; rx_q = di;  end
        2:       begin rx_i = ~di; rx_q = ~dq; end
        3:       begin rx_i = dq;  rx_q = ~di; end
        default: begin rx_i = di;  rx_q = dq;  end
      endcase
      if (s >= f_lo && s <= f_hi) rx_i = ~rx_i;
      if (rst_at >= 0 && s == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("async ber_I", s, int'(ber_i), 0);
        chk("async ber_Q", s, int'(ber_q), 0);
        chk("async err_I", s, int'(err_i), 0);
        chk("async err_Q", s, int'(err_q), 0);
        chk("async rot",   s, int'(rot),   0);
      end
      if (rst_at >= 0 && s == rst_at + 1) rst_n = 1'b1;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d unobserved samples, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    // No rotation: idle zeros, lock boundary, 100 counts, bit-count saturation.
    push(5, 0, 0, 0, 0);
    push(10, 0, 0, 0, 0);
    push(58, 0, 0, 0, 0);
    push(59, 0, 0, 0, 0);
    push(60, 1, 0, 0, 0);
    push(159, 100, 0, 0, 0);
    push(185, 126, 0, 0, 0);
    push(186, 127, 0, 0, 0);
    push(190, 127, 0, 0, 0);
    run_test(0, 192, -1, -2, -1);

    // Rotated receptions: rotation appears exactly on lock.
    for (int k = 1; k < 4; k++) begin
      push(58, 0, 0, 0, 0);
      push(59, 0, 0, 0, k);
      push(159, 100, 0, 0, k);
      run_test(k, 160, -1, -2, -1);
    end

    // Single flipped I bit after lock.
    push(120, 61, 0, 0, 0);
    push(121, 62, 1, 0, 0);
    push(140, 81, 1, 0, 0);
    run_test(0, 141, 120, 120, -1);

    // 16 consecutive I errors saturate the 4-bit error counter.
    push(144, 85, 14, 0, 0);
    push(145, 86, 15, 0, 0);
    push(146, 87, 15, 0, 0);
    push(150, 91, 15, 0, 0);
    run_test(0, 151, 130, 145, -1);

    // Reset during COUNT past START_SYN: clears and stays idle.
    push(70, 11, 0, 0, 0);
    push(100, 0, 0, 0, 0);
    push(130, 0, 0, 0, 0);
    run_test(0, 131, -1, -2, 80);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
